// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_arb_pkg : shared widths and state encoding for burst arbiters |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package sdram_arb_pkg;
  localparam int ADDR_W    = 25;
  localparam int LEN_W     = 11;
  localparam int NUM_PORTS = 2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_STREAM = 1'b1
  } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/sdram_burst_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick  : combinational round-robin picker, search starts at ptr+1  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_pending,
  input  logic [PTR_W-1:0] i_rr_ptr,
  output logic [N-1:0]     o_grant_oh,
  output logic [PTR_W-1:0] o_grant_idx,
  output logic             o_any
);
  int               w_idx;
  logic [PTR_W-1:0] w_sel;

  // The current owner (offset N) is checked last so it cannot win twice
  // in a row while anybody else is waiting.
  always_comb begin
    o_grant_oh  = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = 0;
    w_sel       = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(i_rr_ptr) + k) % N;
      w_sel = w_idx[PTR_W-1:0];
      if (!o_any && i_pending[w_sel]) begin
        o_any             = 1'b1;
        o_grant_oh[w_sel] = 1'b1;
        o_grant_idx       = w_sel;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/sdram_burst_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_burst_arbiter : round-robin share of one io_sdram burst port   |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module sdram_burst_arbiter #(
  parameter int NUM_PORTS = sdram_arb_pkg::NUM_PORTS,
  parameter int ADDR_W    = sdram_arb_pkg::ADDR_W,
  parameter int LEN_W     = sdram_arb_pkg::LEN_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        i_req_rd,
  input  logic [NUM_PORTS*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_PORTS*LEN_W-1:0]  i_req_len,
  input  logic [NUM_PORTS-1:0]        i_req_32bit,
  output logic [31:0]                 o_req_data,
  output logic [NUM_PORTS-1:0]        o_req_data_valid,
  output logic [NUM_PORTS-1:0]        o_req_data_done,
  output logic [NUM_PORTS-1:0]        o_req_busy,
  output logic [NUM_PORTS-1:0]        o_err_overrun,
  output logic                        o_burst_rd,
  output logic [ADDR_W-1:0]           o_burst_addr,
  output logic [LEN_W-1:0]            o_burst_len,
  output logic                        o_burst_32bit,
  input  logic [31:0]                 i_burst_data,
  input  logic                        i_burst_data_valid,
  input  logic                        i_burst_data_done
);
  import sdram_arb_pkg::*;

  localparam int c_PTR_W = $clog2(NUM_PORTS);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [c_PTR_W-1:0]   r_grant;
  logic [c_PTR_W-1:0]   r_rr_ptr;
  logic                 r_burst_rd;
  logic [ADDR_W-1:0]    r_burst_addr;
  logic [LEN_W-1:0]     r_burst_len;
  logic                 r_burst_32bit;
  logic [NUM_PORTS-1:0] r_zero_done;

  logic [NUM_PORTS-1:0] w_pending;
  logic [NUM_PORTS-1:0] w_err;
  logic [ADDR_W-1:0]    w_addr [NUM_PORTS];
  logic [LEN_W-1:0]     w_len  [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_b32;
  logic [NUM_PORTS-1:0] w_pick_oh;
  logic [c_PTR_W-1:0]   w_pick_idx;
  logic                 w_any;
  logic                 w_take;
  logic                 w_issue;
  logic                 w_release;
  logic                 w_streaming;
  logic [NUM_PORTS-1:0] w_own_oh;
  logic [NUM_PORTS-1:0] w_owner_busy;
  logic [NUM_PORTS-1:0] w_accept;
  logic [NUM_PORTS-1:0] w_overrun;

  assign w_streaming  = (r_state == ARB_STREAM);
  assign w_own_oh     = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_grant;
  // The owner frees up in its done cycle, so a request arriving with done
  // is taken rather than flagged as an overrun.
  assign w_owner_busy = (w_streaming && !i_burst_data_done) ? w_own_oh : '0;
  assign w_accept     = i_req_rd & ~w_pending & ~w_owner_busy;
  assign w_overrun    = i_req_rd & ~w_accept;

  rr_pick #(
    .N     (NUM_PORTS),
    .PTR_W (c_PTR_W)
  ) u_rr_pick (
    .i_pending   (w_pending),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant_oh  (w_pick_oh),
    .o_grant_idx (w_pick_idx),
    .o_any       (w_any)
  );

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic              r_pending;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic              r_b32;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pending <= 1'b0;
        r_err     <= 1'b0;
        r_addr    <= '0;
        r_len     <= '0;
        r_b32     <= 1'b0;
      end else begin
        if (w_accept[gi]) begin
          r_pending <= 1'b1;
          r_addr    <= i_req_addr[gi*ADDR_W +: ADDR_W];
          r_len     <= i_req_len[gi*LEN_W +: LEN_W];
          r_b32     <= i_req_32bit[gi];
        end else if (w_take && w_pick_oh[gi]) begin
          r_pending <= 1'b0;
        end
        if (w_overrun[gi]) begin
          r_err <= 1'b1;
        end
      end
    end

    assign w_pending[gi] = r_pending;
    assign w_err[gi]     = r_err;
    assign w_addr[gi]    = r_addr;
    assign w_len[gi]     = r_len;
    assign w_b32[gi]     = r_b32;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_issue     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_take = 1'b1;
          if (w_len[w_pick_idx] != '0) begin
            w_issue     = 1'b1;
            w_state_nxt = ARB_STREAM;
          end
        end
      end
      ARB_STREAM: begin
        if (i_burst_data_done) begin
          w_release   = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ARB_IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= c_PTR_W'(NUM_PORTS - 1);
      r_burst_rd    <= 1'b0;
      r_burst_addr  <= '0;
      r_burst_len   <= '0;
      r_burst_32bit <= 1'b0;
      r_zero_done   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_rd  <= w_issue;
      r_zero_done <= '0;
      if (w_take) begin
        r_grant <= w_pick_idx;
        if (w_issue) begin
          r_burst_addr  <= w_addr[w_pick_idx];
          r_burst_len   <= w_len[w_pick_idx];
          r_burst_32bit <= w_b32[w_pick_idx];
        end else begin
          // Zero-length request completes locally without touching io_sdram.
          r_zero_done <= w_pick_oh;
          r_rr_ptr    <= w_pick_idx;
        end
      end
      if (w_release) begin
        r_rr_ptr <= r_grant;
      end
    end
  end

  assign o_req_data       = i_burst_data;
  assign o_req_data_valid = (w_streaming && i_burst_data_valid) ? w_own_oh : '0;
  assign o_req_data_done  = r_zero_done |
                            ((w_streaming && i_burst_data_done) ? w_own_oh : '0);
  assign o_req_busy       = w_pending | (w_streaming ? w_own_oh : '0);
  assign o_err_overrun    = w_err;
  assign o_burst_rd       = r_burst_rd;
  assign o_burst_addr     = r_burst_addr;
  assign o_burst_len      = r_burst_len;
  assign o_burst_32bit    = r_burst_32bit;
endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sdram_burst_arbiter : directed self-checking bench, 2 ports       |
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
module tb_sdram_burst_arbiter;
  localparam int NP = 2;
  localparam int AW = 25;
  localparam int LW = 11;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NP-1:0]     i_req_rd = '0;
  logic [NP*AW-1:0]  i_req_addr = '0;
  logic [NP*LW-1:0]  i_req_len = '0;
  logic [NP-1:0]     i_req_32bit = '0;
  logic [31:0]       i_burst_data = '0;
  logic              i_burst_data_valid = 1'b0;
  logic              i_burst_data_done = 1'b0;
  logic [31:0]       o_req_data;
  logic [NP-1:0]     o_req_data_valid;
  logic [NP-1:0]     o_req_data_done;
  logic [NP-1:0]     o_req_busy;
  logic [NP-1:0]     o_err_overrun;
  logic              o_burst_rd;
  logic [AW-1:0]     o_burst_addr;
  logic [LW-1:0]     o_burst_len;
  logic              o_burst_32bit;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  sdram_burst_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_req_rd           (i_req_rd),
    .i_req_addr         (i_req_addr),
    .i_req_len          (i_req_len),
    .i_req_32bit        (i_req_32bit),
    .o_req_data         (o_req_data),
    .o_req_data_valid   (o_req_data_valid),
    .o_req_data_done    (o_req_data_done),
    .o_req_busy         (o_req_busy),
    .o_err_overrun      (o_err_overrun),
    .o_burst_rd         (o_burst_rd),
    .o_burst_addr       (o_burst_addr),
    .o_burst_len        (o_burst_len),
    .o_burst_32bit      (o_burst_32bit),
    .i_burst_data       (i_burst_data),
    .i_burst_data_valid (i_burst_data_valid),
    .i_burst_data_done  (i_burst_data_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic next_cyc();
    @(negedge clk);
    i_req_rd           = '0;
    i_burst_data_valid = 1'b0;
    i_burst_data_done  = 1'b0;
    i_burst_data       = '0;
  endtask

  task automatic set_req(input int port, input logic [AW-1:0] addr,
                         input logic [LW-1:0] len, input logic b32);
    i_req_rd[port]              = 1'b1;
    i_req_addr[port*AW +: AW]   = addr;
    i_req_len[port*LW +: LW]    = len;
    i_req_32bit[port]           = b32;
  endtask

  // Waits (bounded) for the grant, checks the downstream fields, then plays
  // io_sdram: nwords data strobes and a done, either with the last word or after it.
  task automatic run_burst(input int port, input logic [AW-1:0] addr,
                           input logic [LW-1:0] len, input logic b32,
                           input int nwords, input bit same_done,
                           output int t_rd, output int t_done);
    int          n;
    logic [NP-1:0] oh;
    logic [31:0] exp_data;
    oh     = NP'(1) << port;
    n      = 0;
    t_rd   = -1;
    t_done = -1;
    #1;
    while (o_burst_rd !== 1'b1 && n < 40) begin
      next_cyc();
      #1;
      n++;
    end
    checks++;
    if (o_burst_rd !== 1'b1) begin
      errors++;
      $display("FAIL burst_rd_timeout port%0d: burst_rd=%b required 1", port, o_burst_rd);
      return;
    end
    t_rd = cyc_cnt;
    checks++;
    if (o_burst_addr !== addr || o_burst_len !== len || o_burst_32bit !== b32) begin
      errors++;
      $display("FAIL burst_fields port%0d: addr=%h len=%0d b32=%b required addr=%h len=%0d b32=%b",
               port, o_burst_addr, o_burst_len, o_burst_32bit, addr, len, b32);
    end
    next_cyc();
    #1;
    checks++;
    if (o_burst_rd !== 1'b0) begin
      errors++;
      $display("FAIL burst_rd_one_cycle port%0d: burst_rd=%b required 0", port, o_burst_rd);
    end
    for (int w = 0; w < nwords; w++) begin
      next_cyc();
      exp_data           = 32'hA500_0000 | (32'(port) << 8) | 32'(w);
      i_burst_data       = exp_data;
      i_burst_data_valid = 1'b1;
      i_burst_data_done  = same_done && (w == nwords - 1);
      #1;
      checks++;
      if (o_req_data_valid !== oh || o_req_data !== exp_data) begin
        errors++;
        $display("FAIL data_route port%0d word%0d: valid=%b data=%h required valid=%b data=%h",
                 port, w, o_req_data_valid, o_req_data, oh, exp_data);
      end
    end
    if (!same_done) begin
      next_cyc();
      i_burst_data_done = 1'b1;
      #1;
    end
    checks++;
    if (o_req_data_done !== oh) begin
      errors++;
      $display("FAIL done_route port%0d: done=%b required %b", port, o_req_data_done, oh);
    end
    t_done = cyc_cnt;
  endtask

  task automatic test_reset();
    repeat (3) next_cyc();
    #1;
    checks++;
    if ({o_burst_rd, o_burst_addr, o_burst_len, o_burst_32bit} !== '0) begin
      errors++;
      $display("FAIL reset_burst_in: rd=%b addr=%h len=%h b32=%b required all 0",
               o_burst_rd, o_burst_addr, o_burst_len, o_burst_32bit);
    end
    next_cyc();
    reset_n = 1'b1;
    next_cyc();
    #1;
    checks++;
    if ({o_burst_rd, o_burst_addr, o_burst_len, o_burst_32bit} !== '0) begin
      errors++;
      $display("FAIL reset_burst_out: rd=%b addr=%h len=%h b32=%b required all 0",
               o_burst_rd, o_burst_addr, o_burst_len, o_burst_32bit);
    end
    checks++;
    if ({o_req_data_valid, o_req_data_done, o_req_busy, o_err_overrun} !== '0) begin
      errors++;
      $display("FAIL reset_port_out: valid=%b done=%b busy=%b err=%b required all 0",
               o_req_data_valid, o_req_data_done, o_req_busy, o_err_overrun);
    end
  endtask

  task automatic test_simultaneous();
    int t0r, t0d, t1r, t1d;
    next_cyc();
    set_req(0, 25'h001000, 11'd4, 1'b1);
    set_req(1, 25'h002000, 11'd5, 1'b0);
    next_cyc();
    #1;
    checks++;
    if (o_req_busy !== 2'b11) begin
      errors++;
      $display("FAIL simul_busy: busy=%b required 11", o_req_busy);
    end
    run_burst(0, 25'h001000, 11'd4, 1'b1, 4, 1'b1, t0r, t0d);
    run_burst(1, 25'h002000, 11'd5, 1'b0, 5, 1'b0, t1r, t1d);
    checks++;
    if (t1r !== t0d + 2) begin
      errors++;
      $display("FAIL back_to_back: port1 burst_rd cycle=%0d required %0d", t1r, t0d + 2);
    end
  endtask

  task automatic test_fairness();
    int tr, td, p;
    logic [AW-1:0] addr;
    next_cyc();
    set_req(0, 25'h00A000, 11'd3, 1'b0);
    set_req(1, 25'h00B000, 11'd3, 1'b0);
    for (int r = 0; r < 6; r++) begin
      p    = r % 2;
      addr = (p == 0) ? 25'h00A000 : 25'h00B000;
      run_burst(p, addr, 11'd3, 1'b0, 2, (r % 2) == 1, tr, td);
      // Re-request in the done cycle itself: must latch, not overrun.
      if (r < 4) set_req(p, addr, 11'd3, 1'b0);
    end
    next_cyc();
    #1;
    checks++;
    if (o_err_overrun !== 2'b00 || o_req_busy !== 2'b00) begin
      errors++;
      $display("FAIL fairness_tail: err=%b busy=%b required 00/00", o_err_overrun, o_req_busy);
    end
  endtask

  task automatic test_single();
    int c0, tr, td;
    next_cyc();
    set_req(0, 25'h000100, 11'd16, 1'b0);
    c0 = cyc_cnt;
    run_burst(0, 25'h000100, 11'd16, 1'b0, 8, 1'b0, tr, td);
    checks++;
    if (tr !== c0 + 2) begin
      errors++;
      $display("FAIL request_latency: burst_rd cycle=%0d required %0d", tr, c0 + 2);
    end
    next_cyc();
    #1;
    checks++;
    if (o_req_busy !== 2'b00 || o_req_data_done !== 2'b00) begin
      errors++;
      $display("FAIL single_tail: busy=%b done=%b required 00/00", o_req_busy, o_req_data_done);
    end
  endtask

  task automatic test_overrun();
    int tr, td, extra;
    next_cyc();
    set_req(1, 25'h003000, 11'd2, 1'b0);
    next_cyc();
    i_req_rd[1] = 1'b1;
    #1;
    checks++;
    if (o_req_busy !== 2'b10) begin
      errors++;
      $display("FAIL overrun_busy: busy=%b required 10", o_req_busy);
    end
    next_cyc();
    i_req_rd[1] = 1'b1;
    run_burst(1, 25'h003000, 11'd2, 1'b0, 3, 1'b0, tr, td);
    next_cyc();
    #1;
    checks++;
    if (o_err_overrun !== 2'b10) begin
      errors++;
      $display("FAIL overrun_flag: err=%b required 10", o_err_overrun);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_burst_rd === 1'b1) extra++;
      next_cyc();
      #1;
    end
    checks++;
    if (extra !== 0 || o_req_busy !== 2'b00) begin
      errors++;
      $display("FAIL overrun_single_burst: extra bursts=%0d busy=%b required 0/00", extra, o_req_busy);
    end
  endtask

  task automatic test_zero_len();
    next_cyc();
    set_req(0, 25'h004000, 11'd0, 1'b1);
    next_cyc();
    #1;
    checks++;
    if (o_req_data_done !== 2'b00 || o_burst_rd !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_c1: done=%b rd=%b required 00/0", o_req_data_done, o_burst_rd);
    end
    next_cyc();
    #1;
    checks++;
    if (o_req_data_done !== 2'b01 || o_burst_rd !== 1'b0 || o_burst_addr !== 25'h003000) begin
      errors++;
      $display("FAIL zero_len_c2: done=%b rd=%b addr=%h required 01/0/003000",
               o_req_data_done, o_burst_rd, o_burst_addr);
    end
    next_cyc();
    #1;
    checks++;
    if (o_req_data_done !== 2'b00 || o_burst_rd !== 1'b0 || o_req_busy !== 2'b00) begin
      errors++;
      $display("FAIL zero_len_c3: done=%b rd=%b busy=%b required 00/0/00",
               o_req_data_done, o_burst_rd, o_req_busy);
    end
  endtask

  task automatic test_reset_mid_stream();
    int n, leaks, tr, td;
    next_cyc();
    set_req(0, 25'h005000, 11'd8, 1'b0);
    n = 0;
    #1;
    while (o_burst_rd !== 1'b1 && n < 40) begin
      next_cyc();
      #1;
      n++;
    end
    checks++;
    if (o_burst_rd !== 1'b1) begin
      errors++;
      $display("FAIL midrst_grant_timeout: burst_rd=%b required 1", o_burst_rd);
    end
    for (int w = 0; w < 3; w++) begin
      next_cyc();
      i_burst_data_valid = 1'b1;
      i_burst_data       = 32'(w);
      #1;
      checks++;
      if (o_req_data_valid !== 2'b01) begin
        errors++;
        $display("FAIL midrst_word%0d: valid=%b required 01", w, o_req_data_valid);
      end
    end
    next_cyc();
    i_burst_data_valid = 1'b1;
    reset_n            = 1'b0;
    #1;
    checks++;
    if ({o_req_data_valid, o_req_data_done, o_req_busy, o_err_overrun, o_burst_rd,
         o_burst_addr, o_burst_len, o_burst_32bit} !== '0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b done=%b busy=%b err=%b rd=%b addr=%h len=%h required all 0",
               o_req_data_valid, o_req_data_done, o_req_busy, o_err_overrun, o_burst_rd,
               o_burst_addr, o_burst_len);
    end
    next_cyc();
    next_cyc();
    reset_n = 1'b1;
    leaks = 0;
    for (int w = 4; w < 8; w++) begin
      next_cyc();
      i_burst_data_valid = 1'b1;
      i_burst_data_done  = (w == 7);
      #1;
      if (o_req_data_valid !== 2'b00 || o_req_data_done !== 2'b00 || o_req_busy !== 2'b00 ||
          o_err_overrun !== 2'b00 || o_burst_rd !== 1'b0) leaks++;
    end
    checks++;
    if (leaks !== 0) begin
      errors++;
      $display("FAIL midrst_residual: %0d cycles with port activity, required 0", leaks);
    end
    next_cyc();
    set_req(1, 25'h006000, 11'd4, 1'b1);
    run_burst(1, 25'h006000, 11'd4, 1'b1, 4, 1'b1, tr, td);
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_fairness();
    test_single();
    test_overrun();
    test_zero_len();
    test_reset_mid_stream();
    next_cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
